// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flip-flop.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one difference bit per cycle, WIDTH cycles
// DONE  | done pulse; a new start is accepted here for back-to-back use
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = {d_bit, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // Outputs are only published on the final bit so they hold across later SHIFT phases.
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bout  <= br_next;
            zero  <= (res_next == '0);
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: expected results are queued
// when an operation is issued and compared when done pulses.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;
  } exp_t;

  exp_t sb[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic bi);
    logic [WIDTH:0] full;
    exp_t e;
    full   = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, bi};
    e.diff = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.zero = (full[WIDTH-1:0] == '0);
    e.ovf  = (av[WIDTH-1] ^ bv[WIDTH-1]) & (av[WIDTH-1] ^ full[WIDTH-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted start; leaves the bench just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(model(av, bv, bi));
  endtask

  // Waits for done, checking busy and latency, then compares against the queue head.
  task automatic collect(input string name, input int exp_lat);
    int   n = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy profile wrong (busy at done=%b), required high until done", name, busy);
    end
    e = sb.pop_front();
    checks++;
    if ({diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
      errors++;
      $display("FAIL %s result: diff=%h bout=%b zero=%b ovf=%b, required diff=%h bout=%b zero=%b ovf=%b",
               name, diff, bout, zero, ovf, e.diff, e.bout, e.zero, e.ovf);
    end
  endtask

  task automatic check_done_low(input string name);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after-done: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, diff, bout, zero, ovf} !== '0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
               busy, done, diff, bout, zero, ovf);
    end
    tick();
  endtask

  task automatic test_vectors();
    issue(8'd5, 8'd3, 1'b0);     collect("sub_5_3", WIDTH);      check_done_low("sub_5_3");
    issue(8'd3, 8'd5, 1'b0);     collect("sub_3_5", WIDTH);      check_done_low("sub_3_5");
    issue(8'h80, 8'h01, 1'b0);   collect("ovf_80_01", WIDTH);
    issue(8'h7F, 8'hFF, 1'b0);   collect("ovf_7f_ff", WIDTH);
    issue(8'h37, 8'h37, 1'b0);   collect("zero_37", WIDTH);
    issue(8'h00, 8'h00, 1'b1);   collect("bin_00_00", WIDTH);
    for (int i = 0; i < 6; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      collect("random", WIDTH);
    end
  endtask

  task automatic test_start_while_busy();
    issue(8'd9, 8'd4, 1'b0);
    tick();
    tick();
    a = 8'd1; b = 8'd2; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    collect("ignore_busy_start", WIDTH - 3);
  endtask

  task automatic test_back_to_back();
    exp_t prev;
    issue(8'd1, 8'd2, 1'b0);
    collect("b2b_first", WIDTH);
    prev = model(8'd1, 8'd2, 1'b0);
    issue(8'd1, 8'd2, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b restart: done=%b busy=%b, required 0 1", done, busy);
    end
    collect("b2b_second", WIDTH);
    // Next op: results must hold the previous value while shifting.
    issue(8'h10, 8'h01, 1'b0);
    tick();
    tick();
    checks++;
    if ({diff, bout} !== {prev.diff, prev.bout}) begin
      errors++;
      $display("FAIL hold during shift: diff=%h bout=%b, required %h %b", diff, bout, prev.diff, prev.bout);
    end
    collect("hold_next", WIDTH - 2);
  endtask

  task automatic test_reset_mid_op();
    bit saw_done = 1'b0;
    issue(8'h55, 8'h22, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    checks++;
    if ({busy, done, diff, bout, zero, ovf} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
               busy, done, diff, bout, zero, ovf);
    end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset done: done pulsed after abort, required none");
    end
    rst = 1'b1; start = 1'b1; a = 8'd7; b = 8'd1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_same_cycle: busy=%b, required 0", busy);
    end
    issue(8'hA0, 8'h0B, 1'b1);
    collect("after_reset", WIDTH);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_while_busy();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
